// File: rtl/ram_read_sequencer.sv
// Read address / enable sequencer feeding the RAM-to-line-buffer stage.
// Optional stall counter output is enabled with `define RSEQ_PERF_CNT_EN.
module ram_read_sequencer #(
    parameter int ADDR_WIDTH        = 11,
    parameter int WEIGHT_BASE       = 1024,
    parameter int WEIGHT_COUNT      = 150,
    parameter int IMAGE_BASE        = 0,
    parameter int FEATURE_MAP1_SIZE = 32,
    parameter int FEATURE_MAP2_SIZE = 28,
    parameter int FEATURE_MAP3_SIZE = 14,
    parameter int FEATURE_MAP4_SIZE = 10,
    parameter int FEATURE_MAP5_SIZE = 5,
    parameter int RD_LATENCY        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_weights,
    input  logic [2:0]            mode_in,
    input  logic                  ready,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  en,
    output logic                  WorI,
    output logic [2:0]            mode,
    output logic                  busy,
    output logic                  pix_valid,
    output logic [5:0]            pix_row,
    output logic [5:0]            pix_col,
    output logic                  w_valid,
    output logic                  done,
    output logic                  err
`ifdef RSEQ_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        W_RD,
        I_RD,
        DRAIN,
        DONE
    } state_t;

    localparam int K_W = $clog2(WEIGHT_COUNT + 1);
    localparam int D_W = $clog2(RD_LATENCY + 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            mode_q;
    logic [5:0]            size_q;
    logic [K_W-1:0]        k_q;
    logic [5:0]            r_q, c_q;
    logic [D_W-1:0]        dcnt_q;
    logic                  err_q;

    logic [RD_LATENCY-1:0] pv_pipe, wv_pipe;
    logic [5:0]            row_pipe [RD_LATENCY];
    logic [5:0]            col_pipe [RD_LATENCY];

    logic mode_ok, start_ok, last_w, last_px;

    function automatic logic [5:0] side(input logic [2:0] m);
        logic [5:0] s;
        unique case (m)
            3'd0:    s = 6'(FEATURE_MAP1_SIZE);
            3'd1:    s = 6'(FEATURE_MAP2_SIZE);
            3'd2:    s = 6'(FEATURE_MAP3_SIZE);
            3'd3:    s = 6'(FEATURE_MAP4_SIZE);
            3'd4:    s = 6'(FEATURE_MAP5_SIZE);
            default: s = 6'(FEATURE_MAP1_SIZE);
        endcase
        return s;
    endfunction

    assign mode_ok  = (mode_in <= 3'd4);
    assign start_ok = (state_q == IDLE) && start && mode_ok;
    assign last_w   = (k_q == K_W'(WEIGHT_COUNT - 1));
    assign last_px  = (r_q == size_q - 6'd1) && (c_q == size_q - 6'd1);

    // DRAIN is sized so that done coincides with the last data beat arriving
    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        WorI    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok)
                    state_d = load_weights ? W_RD : I_RD;
            end
            W_RD: begin
                en   = ready;
                WorI = 1'b1;
                if (ready && last_w)
                    state_d = I_RD;
            end
            I_RD: begin
                en = ready;
                if (ready && last_px)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (int'(dcnt_q) + 2 >= RD_LATENCY)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= '0;
            size_q  <= '0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && start && !mode_ok;
            if (start_ok) begin
                mode_q <= mode_in;
                size_q <= side(mode_in);
                k_q    <= '0;
                r_q    <= '0;
                c_q    <= '0;
                dcnt_q <= '0;
                addr_q <= load_weights ? ADDR_WIDTH'(WEIGHT_BASE)
                                       : ADDR_WIDTH'(IMAGE_BASE);
            end
            if (state_q == W_RD && ready) begin
                if (last_w) begin
                    k_q    <= '0;
                    addr_q <= ADDR_WIDTH'(IMAGE_BASE);
                end else begin
                    k_q    <= k_q + K_W'(1);
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
            // raster order is contiguous, so the address simply increments
            if (state_q == I_RD && ready && !last_px) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                if (c_q == size_q - 6'd1) begin
                    c_q <= '0;
                    r_q <= r_q + 6'd1;
                end else begin
                    c_q <= c_q + 6'd1;
                end
            end
            if (state_q == DRAIN)
                dcnt_q <= dcnt_q + D_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_pipe <= '0;
            wv_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                row_pipe[i] <= '0;
                col_pipe[i] <= '0;
            end
        end else begin
            pv_pipe[0]  <= en && !WorI;
            wv_pipe[0]  <= en && WorI;
            row_pipe[0] <= WorI ? 6'd0 : r_q;
            col_pipe[0] <= WorI ? 6'd0 : c_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_pipe[i]  <= pv_pipe[i-1];
                wv_pipe[i]  <= wv_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
                col_pipe[i] <= col_pipe[i-1];
            end
        end
    end

`ifdef RSEQ_PERF_CNT_EN
    logic stalled;
    assign stalled = (state_q == W_RD || state_q == I_RD) && !ready;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (start_ok)
            stall_cycles <= '0;
        else if (stalled && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

    assign read_addr = addr_q;
    assign mode      = mode_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign pix_valid = pv_pipe[RD_LATENCY-1];
    assign w_valid   = wv_pipe[RD_LATENCY-1];
    assign pix_row   = row_pipe[RD_LATENCY-1];
    assign pix_col   = col_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Directed bench for ram_read_sequencer: issue order, tag alignment,
// stalls, illegal mode, mid-job reset and ignored restarts.
module tb_ram_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_weights = 1'b0;
    logic [2:0]  mode_in = 3'd0;
    logic        ready = 1'b1;
    logic [10:0] read_addr;
    logic        en, WorI, busy, pix_valid, w_valid, done, err;
    logic [2:0]  mode;
    logic [5:0]  pix_row, pix_col;
`ifdef RSEQ_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    ram_read_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load_weights (load_weights),
        .mode_in      (mode_in),
        .ready        (ready),
        .read_addr    (read_addr),
        .en           (en),
        .WorI         (WorI),
        .mode         (mode),
        .busy         (busy),
        .pix_valid    (pix_valid),
        .pix_row      (pix_row),
        .pix_col      (pix_col),
        .w_valid      (w_valid),
        .done         (done),
        .err          (err)
`ifdef RSEQ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    logic [10:0] iss_addr[$];
    bit          iss_w[$];
    int          iss_cyc[$];
    int          pv_tag[$];
    int          pv_cyc[$];
    int wv_n, done_n, done_cyc, err_n, err_cyc, busy_n, stall_n, stall_bad;

    always @(negedge clk) begin
        if (en) begin
            iss_addr.push_back(read_addr);
            iss_w.push_back(WorI);
            iss_cyc.push_back(cyc);
        end
        if (pix_valid) begin
            pv_tag.push_back(int'(pix_row) * 64 + int'(pix_col));
            pv_cyc.push_back(cyc);
        end
        if (w_valid) wv_n++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (busy) busy_n++;
        if (busy && !ready && !en) begin
            stall_n++;
            if (read_addr != 11'd27) stall_bad++;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    function automatic longint outs();
        return longint'({read_addr, en, WorI, mode, busy, pix_valid,
                         pix_row, pix_col, w_valid, done, err});
    endfunction

    task automatic clear_logs();
        iss_addr.delete();
        iss_w.delete();
        iss_cyc.delete();
        pv_tag.delete();
        pv_cyc.delete();
        wv_n = 0; done_n = 0; done_cyc = 0; err_n = 0; err_cyc = 0;
        busy_n = 0; stall_n = 0; stall_bad = 0;
    endtask

    task automatic start_job(input logic [2:0] m, input logic lw,
                             output int sc);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode_in = m;
        load_weights = lw;
        @(posedge clk);
        #1;
        start = 1'b0;
        load_weights = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done seen"}, longint'(done_n > 0), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int sc, e, t, n;

        clear_logs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset outputs", outs(), 0);
`ifdef RSEQ_PERF_CNT_EN
        chk("reset stall_cycles", stall_cycles, 0);
`endif

        // mode 4, no weights
        clear_logs();
        start_job(3'd4, 1'b0, sc);
        wait_done("m4", 100);
        chk("m4 issue count", iss_addr.size(), 25);
        chk("m4 first issue cycle", iss_cyc.size() > 0 ? iss_cyc[0] : -1, sc);
        e = 0;
        for (int i = 0; i < iss_addr.size(); i++)
            if (iss_addr[i] != 11'(i) || iss_w[i] || iss_cyc[i] != sc + i) e++;
        chk("m4 addr sequence errs", e, 0);
        chk("m4 pix count", pv_tag.size(), 25);
        e = 0;
        for (int i = 0; i < pv_tag.size() && i < iss_cyc.size(); i++)
            if (pv_tag[i] != (i / 5) * 64 + (i % 5) || pv_cyc[i] != iss_cyc[i] + 2)
                e++;
        chk("m4 pix tag/latency errs", e, 0);
        chk("m4 done cycle", done_cyc, sc + 24 + 2);
        chk("m4 done count", done_n, 1);
        chk("m4 w_valid count", wv_n, 0);
        chk("m4 busy after done", busy, 0);
        chk("m4 mode held", mode, 4);
        chk("m4 en idle", en, 0);

        // mode 0 with weight preload
        clear_logs();
        start_job(3'd0, 1'b1, sc);
        wait_done("m0w", 1400);
        chk("m0w issue count", iss_addr.size(), 150 + 1024);
        e = 0;
        for (int i = 0; i < iss_addr.size(); i++) begin
            if (i < 150) begin
                if (iss_addr[i] != 11'(1024 + i) || !iss_w[i]) e++;
            end else begin
                if (iss_addr[i] != 11'(i - 150) || iss_w[i]) e++;
            end
            if (iss_cyc[i] != sc + i) e++;
        end
        chk("m0w addr/WorI errs", e, 0);
        chk("m0w w_valid count", wv_n, 150);
        chk("m0w pix count", pv_tag.size(), 1024);
        chk("m0w last tag",
            pv_tag.size() > 0 ? pv_tag[pv_tag.size() - 1] : -1, 31 * 64 + 31);
        chk("m0w done cycle", done_cyc, sc + 1173 + 2);

        // mode 3 with 3-cycle stall at pixel (2,7)
        clear_logs();
        start_job(3'd3, 1'b0, sc);
        repeat (27) @(posedge clk);
        #1 ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        wait_done("m3", 200);
        chk("m3 issue count", iss_addr.size(), 100);
        chk("m3 stall cycles seen", stall_n, 3);
        chk("m3 stall addr errs", stall_bad, 0);
        e = 0;
        for (int i = 0; i < iss_addr.size(); i++) begin
            t = (i < 27) ? sc + i : sc + i + 3;
            if (iss_addr[i] != 11'(i) || iss_cyc[i] != t) e++;
        end
        chk("m3 addr/timing errs", e, 0);
        chk("m3 pix count", pv_tag.size(), 100);
        e = 0;
        for (int i = 0; i < pv_tag.size() && i < iss_cyc.size(); i++)
            if (pv_tag[i] != (i / 10) * 64 + (i % 10) || pv_cyc[i] != iss_cyc[i] + 2)
                e++;
        chk("m3 pix tag/gap errs", e, 0);
`ifdef RSEQ_PERF_CNT_EN
        chk("m3 stall_cycles", stall_cycles, 3);
`endif

        // illegal mode
        clear_logs();
        start_job(3'd6, 1'b0, sc);
        repeat (5) @(negedge clk);
        chk("bad mode err count", err_n, 1);
        chk("bad mode err cycle", err_cyc, sc);
        chk("bad mode busy cycles", busy_n, 0);
        chk("bad mode issues", iss_addr.size(), 0);

        // reset at pixel 50 of mode 2, then restart
        clear_logs();
        start_job(3'd2, 1'b0, sc);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst mid-job outputs", outs(), 0);
        clear_logs();
        repeat (6) @(negedge clk);
        chk("no pix after rst", pv_tag.size(), 0);
        clear_logs();
        start_job(3'd2, 1'b0, sc);
        wait_done("m2 restart", 300);
        chk("m2 restart first addr",
            iss_addr.size() > 0 ? longint'(iss_addr[0]) : -1, 0);
        chk("m2 restart pix count", pv_tag.size(), 196);

        // second start mid-job is ignored
        clear_logs();
        start_job(3'd4, 1'b0, sc);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        mode_in = 3'd1;
        load_weights = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        load_weights = 1'b0;
        wait_done("restart ignore", 100);
        n = 0;
        for (int i = 0; i < iss_w.size(); i++) if (iss_w[i]) n++;
        repeat (10) @(negedge clk);
        chk("ignore done count", done_n, 1);
        chk("ignore pix count", pv_tag.size(), 25);
        chk("ignore weight issues", n, 0);
        chk("ignore mode", mode, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
